// File: rtl/core_pkg.sv
// Shared definitions for the ARM-subset core: datapath widths, ALU command
// encodings and the packed decode-control bundle.
package core_pkg;

    localparam int WORD_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 4;
    localparam int EXE_CMD_WIDTH  = 4;

    localparam logic [EXE_CMD_WIDTH-1:0] EXE_CMD_NOP = 4'd0;
    localparam logic [EXE_CMD_WIDTH-1:0] EXE_CMD_MOV = 4'd1;
    localparam logic [EXE_CMD_WIDTH-1:0] EXE_CMD_ADD = 4'd2;
    localparam logic [EXE_CMD_WIDTH-1:0] EXE_CMD_ADC = 4'd3;
    localparam logic [EXE_CMD_WIDTH-1:0] EXE_CMD_SUB = 4'd4;
    localparam logic [EXE_CMD_WIDTH-1:0] EXE_CMD_SBC = 4'd5;
    localparam logic [EXE_CMD_WIDTH-1:0] EXE_CMD_AND = 4'd6;
    localparam logic [EXE_CMD_WIDTH-1:0] EXE_CMD_ORR = 4'd7;
    localparam logic [EXE_CMD_WIDTH-1:0] EXE_CMD_EOR = 4'd8;
    localparam logic [EXE_CMD_WIDTH-1:0] EXE_CMD_MVN = 4'd9;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic wb_en;
        logic branch;
        logic status_en;
    } ctrl_bundle_t;

    localparam int CTRL_BUNDLE_WIDTH = $bits(ctrl_bundle_t);

endpackage

// File: rtl/pipe_field_reg.sv
// One field group of a pipeline register: rst > flush > freeze > load, where a
// load with i_valid low captures the per-instance bubble value instead of i_d.
module pipe_field_reg #(
    parameter int               WIDTH  = 1,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_freeze,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // flush wins over freeze: a stalled instruction behind a taken branch is dead
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_flush) begin
            r_q <= BUBBLE;
        end else if (i_freeze) begin
            r_q <= r_q;
        end else if (!i_valid) begin
            r_q <= BUBBLE;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/id_exe_reg.sv
// ID/EX pipeline register with hold (freeze) and bubble (flush / valid_in=0).
// Optional forwarding source fields are added when ID_EXE_FWD_EN is defined.
module id_exe_reg
    import core_pkg::*;
#(
    parameter int WORD_WIDTH     = core_pkg::WORD_WIDTH,
    parameter int REG_ADDR_WIDTH = core_pkg::REG_ADDR_WIDTH,
    parameter int EXE_CMD_WIDTH  = core_pkg::EXE_CMD_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      freeze,
    input  logic                      flush,
    input  logic                      valid_in,
    input  logic [WORD_WIDTH-1:0]     pc_in,
    input  logic [WORD_WIDTH-1:0]     val_rn_in,
    input  logic [WORD_WIDTH-1:0]     val_rm_in,
    input  logic                      imm_in,
    input  logic [11:0]               shift_operand_in,
    input  logic [23:0]               signed_imm_24_in,
    input  logic [REG_ADDR_WIDTH-1:0] dest_in,
    input  logic [EXE_CMD_WIDTH-1:0]  exe_command_in,
    input  logic                      mem_read_in,
    input  logic                      mem_write_in,
    input  logic                      wb_en_in,
    input  logic                      branch_in,
    input  logic                      status_en_in,
    input  logic                      carry_in,
`ifdef ID_EXE_FWD_EN
    input  logic [REG_ADDR_WIDTH-1:0] src1_in,
    input  logic [REG_ADDR_WIDTH-1:0] src2_in,
    input  logic                      two_src_in,
    output logic [REG_ADDR_WIDTH-1:0] src1_out,
    output logic [REG_ADDR_WIDTH-1:0] src2_out,
    output logic                      two_src_out,
`endif
    output logic                      valid_out,
    output logic [WORD_WIDTH-1:0]     pc_out,
    output logic [WORD_WIDTH-1:0]     val_rn_out,
    output logic [WORD_WIDTH-1:0]     val_rm_out,
    output logic                      imm_out,
    output logic [11:0]               shift_operand_out,
    output logic [23:0]               signed_imm_24_out,
    output logic [REG_ADDR_WIDTH-1:0] dest_out,
    output logic [EXE_CMD_WIDTH-1:0]  exe_command_out,
    output logic                      mem_read_out,
    output logic                      mem_write_out,
    output logic                      wb_en_out,
    output logic                      branch_out,
    output logic                      status_en_out,
    output logic                      carry_out
);

    localparam int CTRL_W = 1 + CTRL_BUNDLE_WIDTH + EXE_CMD_WIDTH;
    localparam int DATA_W = 3 * WORD_WIDTH + REG_ADDR_WIDTH + 1;
    localparam int IMM_W  = 1 + 12 + 24;

    ctrl_bundle_t w_ctrl_in;
    ctrl_bundle_t w_ctrl_q;
    logic         w_valid_q;

    logic [CTRL_W-1:0] w_ctrl_grp_in;
    logic [CTRL_W-1:0] w_ctrl_grp_q;
    logic [DATA_W-1:0] w_data_grp_in;
    logic [DATA_W-1:0] w_data_grp_q;
    logic [IMM_W-1:0]  w_imm_grp_in;
    logic [IMM_W-1:0]  w_imm_grp_q;

    assign w_ctrl_in.mem_read  = mem_read_in;
    assign w_ctrl_in.mem_write = mem_write_in;
    assign w_ctrl_in.wb_en     = wb_en_in;
    assign w_ctrl_in.branch    = branch_in;
    assign w_ctrl_in.status_en = status_en_in;

    // The valid bit rides in the control group so it can never disagree with the
    // control bits: every path that clears one clears the other.
    assign w_ctrl_grp_in = {valid_in, w_ctrl_in, exe_command_in};
    assign w_data_grp_in = {pc_in, val_rn_in, val_rm_in, dest_in, carry_in};
    assign w_imm_grp_in  = {imm_in, shift_operand_in, signed_imm_24_in};

    pipe_field_reg #(
        .WIDTH  (CTRL_W),
        .BUBBLE ('0)
    ) u_ctrl_reg (
        .clk      (clk),
        .rst      (rst),
        .i_flush  (flush),
        .i_freeze (freeze),
        .i_valid  (valid_in),
        .i_d      (w_ctrl_grp_in),
        .o_q      (w_ctrl_grp_q)
    );

    pipe_field_reg #(
        .WIDTH  (DATA_W),
        .BUBBLE ('0)
    ) u_data_reg (
        .clk      (clk),
        .rst      (rst),
        .i_flush  (flush),
        .i_freeze (freeze),
        .i_valid  (valid_in),
        .i_d      (w_data_grp_in),
        .o_q      (w_data_grp_q)
    );

    pipe_field_reg #(
        .WIDTH  (IMM_W),
        .BUBBLE ('0)
    ) u_imm_reg (
        .clk      (clk),
        .rst      (rst),
        .i_flush  (flush),
        .i_freeze (freeze),
        .i_valid  (valid_in),
        .i_d      (w_imm_grp_in),
        .o_q      (w_imm_grp_q)
    );

    assign {w_valid_q, w_ctrl_q, exe_command_out} = w_ctrl_grp_q;
    assign {pc_out, val_rn_out, val_rm_out, dest_out, carry_out} = w_data_grp_q;
    assign {imm_out, shift_operand_out, signed_imm_24_out} = w_imm_grp_q;

    assign valid_out     = w_valid_q;
    assign mem_read_out  = w_ctrl_q.mem_read;
    assign mem_write_out = w_ctrl_q.mem_write;
    assign wb_en_out     = w_ctrl_q.wb_en;
    assign branch_out    = w_ctrl_q.branch;
    assign status_en_out = w_ctrl_q.status_en;

`ifdef ID_EXE_FWD_EN
    localparam int FWD_W = 2 * REG_ADDR_WIDTH + 1;

    logic [FWD_W-1:0] w_fwd_grp_in;
    logic [FWD_W-1:0] w_fwd_grp_q;

    assign w_fwd_grp_in = {src1_in, src2_in, two_src_in};

    pipe_field_reg #(
        .WIDTH  (FWD_W),
        .BUBBLE ('0)
    ) u_fwd_reg (
        .clk      (clk),
        .rst      (rst),
        .i_flush  (flush),
        .i_freeze (freeze),
        .i_valid  (valid_in),
        .i_d      (w_fwd_grp_in),
        .o_q      (w_fwd_grp_q)
    );

    assign {src1_out, src2_out, two_src_out} = w_fwd_grp_q;
`endif

endmodule

// File: tb/tb_id_exe_reg.sv
// Self-checking bench for id_exe_reg: directed scenarios plus randomized
// control/data traffic against a behavioural model of the stage register.
module tb_id_exe_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rn;
        logic [31:0] rm;
        logic        imm;
        logic [11:0] shift;
        logic [23:0] simm;
        logic [3:0]  dest;
        logic [3:0]  cmd;
        logic        mr;
        logic        mw;
        logic        wb;
        logic        br;
        logic        se;
        logic        carry;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic        two_src;
    } fields_t;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    logic    freeze = 1'b0;
    logic    flush = 1'b0;
    fields_t in_s = '0;
    fields_t out_s;
    fields_t exp_s = '0;

    int n_cmp = 0;
    int n_fail = 0;

    logic        valid_out, imm_out, mr_out, mw_out, wb_out, br_out, se_out, carry_out;
    logic [31:0] pc_out, rn_out, rm_out;
    logic [11:0] shift_out;
    logic [23:0] simm_out;
    logic [3:0]  dest_out, cmd_out;
    logic [3:0]  src1_out, src2_out;
    logic        two_src_out;

    always #5 clk = ~clk;

    id_exe_reg dut (
        .clk               (clk),
        .rst               (rst),
        .freeze            (freeze),
        .flush             (flush),
        .valid_in          (in_s.valid),
        .pc_in             (in_s.pc),
        .val_rn_in         (in_s.rn),
        .val_rm_in         (in_s.rm),
        .imm_in            (in_s.imm),
        .shift_operand_in  (in_s.shift),
        .signed_imm_24_in  (in_s.simm),
        .dest_in           (in_s.dest),
        .exe_command_in    (in_s.cmd),
        .mem_read_in       (in_s.mr),
        .mem_write_in      (in_s.mw),
        .wb_en_in          (in_s.wb),
        .branch_in         (in_s.br),
        .status_en_in      (in_s.se),
        .carry_in          (in_s.carry),
`ifdef ID_EXE_FWD_EN
        .src1_in           (in_s.src1),
        .src2_in           (in_s.src2),
        .two_src_in        (in_s.two_src),
        .src1_out          (src1_out),
        .src2_out          (src2_out),
        .two_src_out       (two_src_out),
`endif
        .valid_out         (valid_out),
        .pc_out            (pc_out),
        .val_rn_out        (rn_out),
        .val_rm_out        (rm_out),
        .imm_out           (imm_out),
        .shift_operand_out (shift_out),
        .signed_imm_24_out (simm_out),
        .dest_out          (dest_out),
        .exe_command_out   (cmd_out),
        .mem_read_out      (mr_out),
        .mem_write_out     (mw_out),
        .wb_en_out         (wb_out),
        .branch_out        (br_out),
        .status_en_out     (se_out),
        .carry_out         (carry_out)
    );

`ifndef ID_EXE_FWD_EN
    assign src1_out    = 4'd0;
    assign src2_out    = 4'd0;
    assign two_src_out = 1'b0;
`endif

    assign out_s = '{valid: valid_out, pc: pc_out, rn: rn_out, rm: rm_out, imm: imm_out,
                     shift: shift_out, simm: simm_out, dest: dest_out, cmd: cmd_out,
                     mr: mr_out, mw: mw_out, wb: wb_out, br: br_out, se: se_out,
                     carry: carry_out, src1: src1_out, src2: src2_out, two_src: two_src_out};

    // Model: what the register holds after one edge, from the stage's rules.
    function automatic fields_t model_next(fields_t cur, fields_t nxt, logic r, logic fl, logic fz);
        fields_t res;
        if (r || fl) res = '0;
        else if (fz) res = cur;
        else if (!nxt.valid) res = '0;
        else res = nxt;
`ifndef ID_EXE_FWD_EN
        res.src1 = 4'd0;
        res.src2 = 4'd0;
        res.two_src = 1'b0;
`endif
        return res;
    endfunction

    function automatic fields_t rand_fields();
        fields_t f;
        f.valid   = 1'($urandom());
        f.pc      = $urandom();
        f.rn      = $urandom();
        f.rm      = $urandom();
        f.imm     = 1'($urandom());
        f.shift   = 12'($urandom());
        f.simm    = 24'($urandom());
        f.dest    = 4'($urandom());
        f.cmd     = 4'($urandom_range(9, 0));
        f.mr      = 1'($urandom());
        f.mw      = 1'($urandom());
        f.wb      = 1'($urandom());
        f.br      = 1'($urandom());
        f.se      = 1'($urandom());
        f.carry   = 1'($urandom());
        f.src1    = 4'($urandom());
        f.src2    = 4'($urandom());
        f.two_src = 1'($urandom());
        return f;
    endfunction

    task automatic cycle();
        exp_s = model_next(exp_s, in_s, rst, flush, freeze);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_s   = '1;
        freeze = 1'b1;
        flush  = 1'b0;
        rst    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_cmp++;
            if (out_s !== fields_t'('0)) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %h want 0", i, out_s);
            end
        end
        n_cmp++;
        if (valid_out !== 1'b0 || carry_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid_carry: got valid=%b carry=%b want 0/0", valid_out, carry_out);
        end
        rst    = 1'b0;
        freeze = 1'b0;
    endtask

    task automatic load_add();
        in_s       = '0;
        in_s.valid = 1'b1;
        in_s.cmd   = 4'b0010;
        in_s.wb    = 1'b1;
        in_s.dest  = 4'd3;
        in_s.rn    = 32'h10;
        in_s.rm    = 32'h20;
        cycle();
    endtask

    task automatic test_normal_load();
        load_add();
        n_cmp++;
        if (valid_out !== 1'b1 || cmd_out !== 4'b0010 || wb_out !== 1'b1 || dest_out !== 4'd3 ||
            rn_out !== 32'h10 || rm_out !== 32'h20) begin
            n_fail++;
            $display("FAIL normal_load: got v=%b cmd=%h wb=%b dest=%0d rn=%h rm=%h want 1/2/1/3/10/20",
                     valid_out, cmd_out, wb_out, dest_out, rn_out, rm_out);
        end
        n_cmp++;
        if (out_s !== exp_s) begin
            n_fail++;
            $display("FAIL normal_load_all: got %h want %h", out_s, exp_s);
        end
    endtask

    task automatic test_freeze();
        load_add();
        freeze    = 1'b1;
        in_s.cmd  = 4'b0100;
        in_s.dest = 4'd5;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_cmp++;
            if (cmd_out !== 4'b0010 || dest_out !== 4'd3 || valid_out !== 1'b1) begin
                n_fail++;
                $display("FAIL freeze_hold[%0d]: got cmd=%h dest=%0d v=%b want 2/3/1",
                         i, cmd_out, dest_out, valid_out);
            end
        end
        freeze = 1'b0;
        cycle();
        n_cmp++;
        if (cmd_out !== 4'b0100 || dest_out !== 4'd5) begin
            n_fail++;
            $display("FAIL freeze_release: got cmd=%h dest=%0d want 4/5", cmd_out, dest_out);
        end
    endtask

    task automatic test_flush_beats_freeze();
        in_s       = rand_fields();
        in_s.valid = 1'b1;
        in_s.mw    = 1'b1;
        in_s.wb    = 1'b0;
        in_s.cmd   = 4'b0010;
        cycle();
        n_cmp++;
        if (mw_out !== 1'b1) begin
            n_fail++;
            $display("FAIL str_load: got mem_write=%b want 1", mw_out);
        end
        flush  = 1'b1;
        freeze = 1'b1;
        in_s   = rand_fields();
        in_s.valid = 1'b1;
        cycle();
        n_cmp++;
        if (mw_out !== 1'b0 || wb_out !== 1'b0 || valid_out !== 1'b0 || cmd_out !== 4'd0) begin
            n_fail++;
            $display("FAIL flush_over_freeze: got mw=%b wb=%b v=%b cmd=%h want 0/0/0/0",
                     mw_out, wb_out, valid_out, cmd_out);
        end
        n_cmp++;
        if (out_s !== fields_t'('0)) begin
            n_fail++;
            $display("FAIL flush_all_zero: got %h want 0", out_s);
        end
        flush  = 1'b0;
        freeze = 1'b0;
    endtask

    task automatic test_carry_capture();
        in_s       = rand_fields();
        in_s.valid = 1'b1;
        in_s.cmd   = 4'b0011;
        in_s.carry = 1'b1;
        cycle();
        in_s.carry = 1'b0;
        freeze     = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_cmp++;
            if (carry_out !== 1'b1 || cmd_out !== 4'b0011) begin
                n_fail++;
                $display("FAIL carry_hold[%0d]: got carry=%b cmd=%h want 1/3", i, carry_out, cmd_out);
            end
        end
        freeze = 1'b0;
        cycle();
        n_cmp++;
        if (carry_out !== 1'b0) begin
            n_fail++;
            $display("FAIL carry_reload: got %b want 0", carry_out);
        end
    endtask

    task automatic test_bubble_valid();
        in_s       = rand_fields();
        in_s.valid = 1'b0;
        in_s.wb    = 1'b1;
        in_s.br    = 1'b1;
        in_s.src1  = 4'd7;
        in_s.src2  = 4'd9;
        cycle();
        n_cmp++;
        if (valid_out !== 1'b0 || wb_out !== 1'b0 || br_out !== 1'b0 ||
            src1_out !== 4'd0 || src2_out !== 4'd0) begin
            n_fail++;
            $display("FAIL bubble_valid_in: got v=%b wb=%b br=%b s1=%0d s2=%0d want all 0",
                     valid_out, wb_out, br_out, src1_out, src2_out);
        end
        n_cmp++;
        if (out_s !== fields_t'('0)) begin
            n_fail++;
            $display("FAIL bubble_all_zero: got %h want 0", out_s);
        end
    endtask

    task automatic test_midop_reset();
        load_add();
        freeze = 1'b1;
        cycle();
        rst = 1'b1;
        cycle();
        n_cmp++;
        if (out_s !== fields_t'('0)) begin
            n_fail++;
            $display("FAIL midop_reset: got %h want 0", out_s);
        end
        rst    = 1'b0;
        freeze = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            in_s   = rand_fields();
            rst    = ($urandom_range(39, 0) == 0);
            flush  = ($urandom_range(7, 0) == 0);
            freeze = ($urandom_range(3, 0) == 0);
            cycle();
            n_cmp++;
            if (out_s !== exp_s) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h want %h", i, out_s, exp_s);
            end
            n_cmp++;
            if (!valid_out && (wb_out || mw_out || br_out || se_out || mr_out)) begin
                n_fail++;
                $display("FAIL bubble_invariant[%0d]: got ctrl=%b%b%b%b%b want 00000 with valid=0",
                         i, mr_out, mw_out, wb_out, br_out, se_out);
            end
        end
        rst    = 1'b0;
        flush  = 1'b0;
        freeze = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal_load();
        test_freeze();
        test_flush_beats_freeze();
        test_carry_capture();
        test_bubble_valid();
        test_midop_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/id_exe_reg.md
Name: id_exe_reg

Overview:
- Pipeline register between the decode stage (register file and decode control logic) and the execute stage (ALU, branch target adder, status update) of the 5-stage ARM-subset core.
- Latches decoded control, operand values, immediate fields and the current carry flag on every clock.
- Supports hold (freeze) for hazard stalls and bubble insertion (flush) for taken branches.
- Tracks a valid bit so downstream stages and debug logic can identify bubbles.

Parameters:
- WORD_WIDTH, 32, width of PC and operand values
- REG_ADDR_WIDTH, 4, register-file index width
- EXE_CMD_WIDTH, 4, ALU command width

Ports:
- clk  in  1  core clock, all updates on rising edge
- rst  in  1  synchronous, active-high reset
- freeze  in  1  hazard stall; hold all contents
- flush  in  1  taken branch in EXE; load a bubble
- valid_in  in  1  decode stage holds a real instruction
- pc_in  in  WORD_WIDTH  PC+4 of decoded instruction
- val_rn_in  in  WORD_WIDTH  first operand value
- val_rm_in  in  WORD_WIDTH  second operand value
- imm_in  in  1  I bit
- shift_operand_in  in  12  shifter operand field
- signed_imm_24_in  in  24  branch offset field
- dest_in  in  REG_ADDR_WIDTH  destination register
- exe_command_in  in  EXE_CMD_WIDTH  ALU command from decode control
- mem_read_in, mem_write_in, wb_en_in, branch_in, status_en_in  in  1 each  decoded control bits
- carry_in  in  1  current C flag from the status register
- all above (except clk/rst/freeze/flush) mirrored as *_out  out  same width; plus valid_out  out  1

Behaviour:
- Single always block on posedge clk. Priority order: rst > flush > freeze > load.
- rst: every output is 0, including valid_out and carry_out.
- flush=1:
  - Control outputs (mem_read, mem_write, wb_en, branch, status_en) go to 0.
  - exe_command_out goes to 0; valid_out goes to 0.
  - Data fields go to 0. No architectural side effect can escape a bubble.
  - flush overrides a simultaneous freeze: the stalled instruction is on the wrong path.
- freeze=1 and flush=0: all outputs hold their previous values, including valid_out.
- Otherwise: every *_out takes its *_in on the next edge. Latency is exactly one cycle; there is no combinational path from input to output.
- valid_in=0 while loading: the stage loads a bubble, identical to the flush contents.
- Control bits are also forced to 0 whenever valid_out would be 0. Invariant: valid_out=0 implies wb_en_out=mem_write_out=branch_out=status_en_out=0.
- carry_in is sampled at load time, so ADC/SBC use the flag current when the instruction left decode.
- Mid-operation reset clears a held (frozen) instruction. No state survives rst.
- No internal FSM beyond the valid bit. There is no counter wrap and no other width conversion.

Optional Feature:
- Macro: ID_EXE_FWD_EN.
- When defined, adds these ports:
  - src1_in/src1_out (REG_ADDR_WIDTH)
  - src2_in/src2_out (REG_ADDR_WIDTH)
  - two_src_in/two_src_out (1)
- These fields follow the same rst/flush/freeze/load rules and are zeroed in bubbles. They feed the execute-stage forwarding unit.
- When undefined, the ports are absent, and EXE takes operands from val_rn_out/val_rm_out only. The hazard unit then relies on freeze.

Decomposition:
- Shared package core_pkg:
  - WORD_WIDTH and REG_ADDR_WIDTH constants
  - EXE_CMD_* encodings (MOV=1, ADD=2, ADC=3, SUB=4, SBC=5, AND=6, ORR=7, EOR=8, MVN=9)
  - ctrl_bundle_t packing mem_read, mem_write, wb_en, branch, status_en
- One sub-module: pipe_field_reg, a parameterised-width register with rst/flush/freeze/load priority and a per-instance bubble value. It is instantiated once per field group (control, data, immediates) so the priority logic exists in one place.

Test Plan:
- Reset: assert rst for 2 cycles with all inputs = 1s → every output is 0 after the edge, including valid_out and carry_out.
- Normal load: valid_in=1, exe_command_in=4'b0010, wb_en_in=1, dest_in=4'd3, val_rn_in=32'h10, val_rm_in=32'h20 → identical values on outputs one cycle later, valid_out=1.
- Freeze: load ADD as above, then freeze=1 for 3 cycles while inputs change to SUB (4'b0100), dest 5 → outputs stay ADD/dest 3 for all 3 cycles. On release, SUB/dest 5 appear next cycle.
- Flush beats freeze: with STR loaded (mem_write_out=1), assert flush=1 and freeze=1 together → next cycle mem_write_out=0, wb_en_out=0, valid_out=0, exe_command_out=0.
- Carry capture: carry_in=1 at load of ADC (4'b0011), then carry_in=0 next cycle with freeze=1 → carry_out remains 1 while frozen.
- Bubble by valid_in: valid_in=0 with wb_en_in=1, branch_in=1 → valid_out=0, wb_en_out=0, branch_out=0. With ID_EXE_FWD_EN, src1_out=src2_out=0.
